// File: rtl/reg_trace_buffer.sv
// Change-capture trace buffer: samples NCH channels, queues each change
// with its timestamp, and stops capturing after a long idle stretch.
module reg_trace_buffer #(
    parameter int WIDTH      = 16,
    parameter int NCH        = 3,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 16,
    parameter int IDLE_LIMIT = 250,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH*WIDTH-1:0] ch_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [WIDTH-1:0]     out_data,
    output logic [TS_W-1:0]      out_ts,
    output logic [CNT_W-1:0]     count,
    output logic                 coalesced,
    output logic                 done
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);

    logic [WIDTH-1:0]  shadow_q [NCH];
    logic [WIDTH-1:0]  shadow_d [NCH];
    logic [WIDTH-1:0]  pval_q   [NCH];
    logic [WIDTH-1:0]  pval_d   [NCH];
    logic [TS_W-1:0]   pts_q    [NCH];
    logic [TS_W-1:0]   pts_d    [NCH];
    logic [NCH-1:0]    pend_q, pend_d;
    logic [WIDTH-1:0]  ch_val   [NCH];
    logic [NCH-1:0]    change;

    logic [CH_W-1:0]   mem_ch_q   [DEPTH];
    logic [WIDTH-1:0]  mem_data_q [DEPTH];
    logic [TS_W-1:0]   mem_ts_q   [DEPTH];

    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              done_q, done_d;
    logic              coal_q, coal_d;

    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [TS_W-1:0]   out_ts_q, out_ts_d;

    logic              sample, has_pend, full, pop, push, remain_zero;
    logic [CH_W-1:0]   sel;
    logic [WIDTH-1:0]  push_data;
    logic [TS_W-1:0]   push_ts;

    assign sample      = en && !done_q;
    assign has_pend    = |pend_q;
    assign out_valid   = (count_q != '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign pop         = out_valid && out_ready;
    assign push        = has_pend && (!full || pop);
    assign push_data   = pval_q[sel];
    assign push_ts     = pts_q[sel];
    assign remain_zero = (count_q == '0) || (pop && count_q == CNT_W'(1));

    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign out_ts    = out_ts_q;
    assign count     = count_q;
    assign coalesced = coal_q;
    assign done      = done_q;

    // Split the flat input bus and flag channels that moved this cycle.
    always_comb begin
        change = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_val[i] = ch_data[i*WIDTH +: WIDTH];
            change[i] = sample && (ch_val[i] != shadow_q[i]);
        end
    end

    // Fixed-priority arbiter: lowest-index pending channel wins.
    always_comb begin
        sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = CH_W'(i);
        end
    end

    // Pending slots: a push clears, a fresh change (re)loads and wins.
    always_comb begin
        pend_d   = pend_q;
        pval_d   = pval_q;
        pts_d    = pts_q;
        shadow_d = shadow_q;
        coal_d   = coal_q | (|(change & pend_q));
        for (int i = 0; i < NCH; i++) begin
            if (push && sel == CH_W'(i)) pend_d[i] = 1'b0;
            if (change[i]) begin
                pend_d[i]   = 1'b1;
                pval_d[i]   = ch_val[i];
                pts_d[i]    = ts_q;
                shadow_d[i] = ch_val[i];
            end
        end
    end

    // Timestamp and idle tracking; done freezes all capture.
    always_comb begin
        ts_d   = ts_q;
        idle_d = idle_q;
        done_d = done_q;
        if (sample) begin
            ts_d = ts_q + TS_W'(1);
            if (|change) begin
                idle_d = '0;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
                if (idle_d == IDLE_W'(IDLE_LIMIT)) done_d = 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy and the registered head entry.
    always_comb begin
        wptr_d     = wptr_q + PTR_W'(push);
        rptr_d     = rptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        out_ch_d   = out_ch_q;
        out_data_d = out_data_q;
        out_ts_d   = out_ts_q;
        if (count_d != '0) begin
            if (remain_zero) begin
                out_ch_d   = sel;
                out_data_d = push_data;
                out_ts_d   = push_ts;
            end else begin
                out_ch_d   = mem_ch_q[rptr_d];
                out_data_d = mem_data_q[rptr_d];
                out_ts_d   = mem_ts_q[rptr_d];
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_ch_q[wptr_q]   <= sel;
            mem_data_q[wptr_q] <= push_data;
            mem_ts_q[wptr_q]   <= push_ts;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q   <= '{default: '0};
            pval_q     <= '{default: '0};
            pts_q      <= '{default: '0};
            pend_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            idle_q     <= '0;
            done_q     <= 1'b0;
            coal_q     <= 1'b0;
            out_ch_q   <= '0;
            out_data_q <= '0;
            out_ts_q   <= '0;
        end else begin
            shadow_q   <= shadow_d;
            pval_q     <= pval_d;
            pts_q      <= pts_d;
            pend_q     <= pend_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ts_q       <= ts_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            coal_q     <= coal_d;
            out_ch_q   <= out_ch_d;
            out_data_q <= out_data_d;
            out_ts_q   <= out_ts_d;
        end
    end

endmodule

// File: tb/tb_reg_trace_buffer.sv
// Directed bench for reg_trace_buffer: vector table plus
// hand-written sequences for full FIFO, idle stop, ts wrap, reset.
module tb_reg_trace_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: defaults
    logic        a_rst = 1'b0, a_en = 1'b0, a_rdy = 1'b0;
    logic [47:0] a_din = '0;
    logic        a_valid, a_coal, a_done;
    logic [1:0]  a_ch;
    logic [15:0] a_dout, a_ts;
    logic [4:0]  a_cnt;

    // Instance B: short idle limit
    logic        b_rst = 1'b0, b_en = 1'b0, b_rdy = 1'b0;
    logic [47:0] b_din = '0;
    logic        b_valid, b_coal, b_done;
    logic [1:0]  b_ch;
    logic [15:0] b_dout, b_ts;
    logic [4:0]  b_cnt;

    // Instance C: 4-bit timestamp
    logic        c_rst = 1'b0, c_en = 1'b0, c_rdy = 1'b0;
    logic [47:0] c_din = '0;
    logic        c_valid, c_coal, c_done;
    logic [1:0]  c_ch;
    logic [15:0] c_dout;
    logic [3:0]  c_ts;
    logic [4:0]  c_cnt;

    reg_trace_buffer dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .ch_data(a_din),
        .out_valid(a_valid), .out_ready(a_rdy), .out_ch(a_ch),
        .out_data(a_dout), .out_ts(a_ts), .count(a_cnt),
        .coalesced(a_coal), .done(a_done)
    );

    reg_trace_buffer #(.IDLE_LIMIT(5)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .ch_data(b_din),
        .out_valid(b_valid), .out_ready(b_rdy), .out_ch(b_ch),
        .out_data(b_dout), .out_ts(b_ts), .count(b_cnt),
        .coalesced(b_coal), .done(b_done)
    );

    reg_trace_buffer #(.TS_W(4)) dut_c (
        .clk(clk), .rst(c_rst), .en(c_en), .ch_data(c_din),
        .out_valid(c_valid), .out_ready(c_rdy), .out_ch(c_ch),
        .out_data(c_dout), .out_ts(c_ts), .count(c_cnt),
        .coalesced(c_coal), .done(c_done)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [47:0] d;
        logic        rdy;
        logic        ev;
        logic [1:0]  ech;
        logic [15:0] edat;
        logic [15:0] ets;
        logic [4:0]  ecnt;
        logic        ecoal;
        logic        edone;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mk(
        input logic rst, input logic en, input logic [47:0] d,
        input logic rdy, input logic ev, input logic [1:0] ech,
        input logic [15:0] edat, input logic [15:0] ets,
        input logic [4:0] ecnt, input logic ecoal, input logic edone
    );
        vec_t v;
        v.rst = rst; v.en = en; v.d = d; v.rdy = rdy;
        v.ev = ev; v.ech = ech; v.edat = edat; v.ets = ets;
        v.ecnt = ecnt; v.ecoal = ecoal; v.edone = edone;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [47:0] abc;
        int got;
        int cyc;
        abc = {16'hC, 16'hB, 16'hA};

        tv[0]  = mk(0, 1, 48'h0,    1, 0, 0, 16'h0,    0,  0, 0, 0);
        tv[1]  = mk(1, 1, 48'h0,    1, 0, 0, 16'h0,    0,  0, 0, 0);
        tv[2]  = mk(1, 1, 48'h0,    1, 0, 0, 16'h0,    0,  0, 0, 0);
        tv[3]  = mk(1, 1, 48'h0,    1, 0, 0, 16'h0,    0,  0, 0, 0);
        tv[4]  = mk(1, 1, 48'h1234, 1, 0, 0, 16'h0,    0,  0, 0, 0);
        tv[5]  = mk(1, 1, 48'h1234, 1, 1, 0, 16'h1234, 3,  1, 0, 0);
        tv[6]  = mk(1, 1, 48'h1234, 1, 0, 0, 16'h1234, 3,  0, 0, 0);
        tv[7]  = mk(1, 1, 48'h1234, 1, 0, 0, 16'h1234, 3,  0, 0, 0);
        tv[8]  = mk(1, 1, 48'h1234, 1, 0, 0, 16'h1234, 3,  0, 0, 0);
        tv[9]  = mk(1, 1, 48'h1234, 1, 0, 0, 16'h1234, 3,  0, 0, 0);
        tv[10] = mk(1, 1, 48'h1234, 1, 0, 0, 16'h1234, 3,  0, 0, 0);
        tv[11] = mk(1, 1, abc,      1, 0, 0, 16'h1234, 3,  0, 0, 0);
        tv[12] = mk(1, 1, abc,      1, 1, 0, 16'hA,    10, 1, 0, 0);
        tv[13] = mk(1, 1, abc,      1, 1, 1, 16'hB,    10, 1, 0, 0);
        tv[14] = mk(1, 1, abc,      1, 1, 2, 16'hC,    10, 1, 0, 0);
        tv[15] = mk(1, 1, abc,      1, 0, 2, 16'hC,    10, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            a_rst = tv[i].rst;
            a_en  = tv[i].en;
            a_din = tv[i].d;
            a_rdy = tv[i].rdy;
            tick();
            chk($sformatf("v%0d.valid", i), 32'(a_valid), 32'(tv[i].ev));
            chk($sformatf("v%0d.ch", i),    32'(a_ch),    32'(tv[i].ech));
            chk($sformatf("v%0d.data", i),  32'(a_dout),  32'(tv[i].edat));
            chk($sformatf("v%0d.ts", i),    32'(a_ts),    32'(tv[i].ets));
            chk($sformatf("v%0d.count", i), 32'(a_cnt),   32'(tv[i].ecnt));
            chk($sformatf("v%0d.coal", i),  32'(a_coal),  32'(tv[i].ecoal));
            chk($sformatf("v%0d.done", i),  32'(a_done),  32'(tv[i].edone));
        end

        // Full FIFO with back-pressure, then drain
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1;
        a_rdy = 1'b0;
        a_din = '0;
        for (int k = 1; k <= 20; k++) begin
            a_din = 48'(k);
            tick();
        end
        chk("full.count", 32'(a_cnt), 32'd16);
        chk("full.coal", 32'(a_coal), 32'd1);
        chk("full.valid", 32'(a_valid), 32'd1);
        chk("full.ch", 32'(a_ch), 32'd0);
        chk("full.data", 32'(a_dout), 32'd1);
        chk("full.ts", 32'(a_ts), 32'd0);
        tick();
        chk("hold.data", 32'(a_dout), 32'd1);
        chk("hold.count", 32'(a_cnt), 32'd16);
        a_rdy = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 17 && cyc < 40) begin
            if (a_valid) begin
                chk($sformatf("drain%0d.ch", got), 32'(a_ch), 32'd0);
                chk($sformatf("drain%0d.data", got), 32'(a_dout),
                    (got < 16) ? 32'(got + 1) : 32'd20);
                chk($sformatf("drain%0d.ts", got), 32'(a_ts),
                    (got < 16) ? 32'(got) : 32'd19);
                got++;
            end
            tick();
            cyc++;
        end
        chk("drain.entries", 32'(got), 32'd17);
        chk("drain.count", 32'(a_cnt), 32'd0);
        chk("drain.valid", 32'(a_valid), 32'd0);
        chk("drain.hold", 32'(a_dout), 32'd20);

        // Mid-operation reset with entries and pending data
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1;
        a_rdy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            a_din = 48'(k);
            tick();
        end
        chk("pre_rst.count", 32'(a_cnt), 32'd4);
        a_rst = 1'b0;
        a_rdy = 1'b1;
        tick();
        chk("rst.count", 32'(a_cnt), 32'd0);
        chk("rst.valid", 32'(a_valid), 32'd0);
        chk("rst.coal", 32'(a_coal), 32'd0);
        chk("rst.done", 32'(a_done), 32'd0);
        chk("rst.data", 32'(a_dout), 32'd0);
        chk("rst.ts", 32'(a_ts), 32'd0);
        a_rst = 1'b1;
        a_din = {16'h0, 16'h55, 16'h0};
        tick();
        chk("resume.valid0", 32'(a_valid), 32'd0);
        tick();
        chk("resume.valid", 32'(a_valid), 32'd1);
        chk("resume.ch", 32'(a_ch), 32'd1);
        chk("resume.data", 32'(a_dout), 32'h55);
        chk("resume.ts", 32'(a_ts), 32'd0);

        // Idle limit with an en=0 gap
        b_rst = 1'b0;
        tick();
        b_rst = 1'b1;
        b_en = 1'b1;
        b_rdy = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        b_en = 1'b0;
        tick();
        tick();
        b_en = 1'b1;
        tick();
        chk("idle4.done", 32'(b_done), 32'd0);
        tick();
        chk("idle5.done", 32'(b_done), 32'd1);
        b_din = 48'h77_0000_0077;
        for (int k = 0; k < 3; k++) tick();
        chk("after_done.count", 32'(b_cnt), 32'd0);
        chk("after_done.valid", 32'(b_valid), 32'd0);
        chk("after_done.done", 32'(b_done), 32'd1);
        chk("after_done.ts", 32'(dut_b.ts_q), 32'd5);

        // Timestamp wrap on a 4-bit counter
        c_rst = 1'b0;
        tick();
        c_rst = 1'b1;
        c_en = 1'b1;
        c_rdy = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        c_din = 48'h1;
        tick();
        c_din = 48'h2;
        tick();
        chk("wrap1.valid", 32'(c_valid), 32'd1);
        chk("wrap1.data", 32'(c_dout), 32'd1);
        chk("wrap1.ts", 32'(c_ts), 32'd15);
        tick();
        chk("wrap2.valid", 32'(c_valid), 32'd1);
        chk("wrap2.data", 32'(c_dout), 32'd2);
        chk("wrap2.ts", 32'(c_ts), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
